// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Multi-cycle unsigned restoring divider. Each RUN cycle does one trial
//   subtraction through a (WIDTH+1)-bit ripple of full-subtractor cells. The
//   borrow-out of that ripple chooses between keeping the difference and
//   restoring the shifted partial remainder.
//
// Ports
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset, clears all state
//   start        request, sampled only in IDLE
//   dividend     unsigned operand, captured on the accepting edge
//   divisor      unsigned operand, captured on the accepting edge
//   busy         high in RUN and DONE
//   done         one-cycle pulse in DONE
//   quotient     result, held until the next accepted start
//   remainder    result, held until the next accepted start
//   div_by_zero  set with done when the captured divisor was zero

// One-bit full subtractor: d = a - b - bin, with borrow-out bout.
module full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;

    logic [WIDTH-1:0] q_r, r_r, d_r;
    logic [CW-1:0]    count;

    logic             last_iter;
    assign last_iter = (count == CW'(WIDTH - 1));

    // Partial remainder shifted left with the dividend MSB entering. It is
    // kept WIDTH+1 bits wide because it can reach 2*D-1.
    logic [WIDTH:0]   r_sh;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] brw;

    assign r_sh   = {r_r, q_r[WIDTH-1]};
    assign sub_b  = {1'b0, d_r};
    assign brw[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i <= WIDTH; i++) begin : g_sub
            full_sub u_fs (
                .a    (r_sh[i]),
                .b    (sub_b[i]),
                .bin  (brw[i]),
                .d    (trial[i]),
                .bout (brw[i+1])
            );
        end
    endgenerate

    // No borrow: the difference is non-negative and < D, so it fits WIDTH bits.
    // Borrow: r_sh < D, so restoring also fits WIDTH bits.
    logic             keep;
    logic [WIDTH-1:0] r_nx, q_nx;

    assign keep = ~brw[WIDTH+1];
    assign r_nx = keep ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
    assign q_nx = {q_r[WIDTH-2:0], keep};

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_nx = DONE;
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath. The visible result registers load only on the edge that
    // enters DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_r         <= '0;
            r_r         <= '0;
            d_r         <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            q_r   <= dividend;
                            r_r   <= '0;
                            d_r   <= divisor;
                            count <= '0;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    q_r   <= q_nx;
                    r_r   <= r_nx;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        quotient    <= q_nx;
                        remainder   <= r_nx;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse and wait for done. Returns edges after the
    // accepting edge until done was seen, and the busy-high cycle count.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int busy_cyc);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();                      // accepting edge
        start    = 1'b0;
        dividend = 8'hA5;            // operands may change freely now
        divisor  = 8'h00;
        lat      = 0;
        busy_cyc = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cyc++;
            tick();
            lat++;
        end
        if (busy) busy_cyc++;        // the DONE cycle
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic do_check(input string tag, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int exp_q,
                            input int exp_r, input int exp_lat);
        int lat, bc;
        run_div(a, b, lat, bc);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_q"}, quotient, exp_q);
        chk({tag, "_r"}, remainder, exp_r);
        chk({tag, "_dbz"}, div_by_zero, (b == 0) ? 1 : 0);
        tick();
        chk({tag, "_done_drop"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_q_held"}, quotient, exp_q);
    endtask

    initial begin
        int lat, bc, pulses;
        logic [W-1:0] a, b;

        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        reset_n = 1'b1;
        tick();

        // 100/7: done visible after edge 8, busy for 9 cycles
        run_div(8'd100, 8'd7, lat, bc);
        chk("d100_7_lat", lat, 8);
        chk("d100_7_busy", bc, 9);
        chk("d100_7_q", quotient, 14);
        chk("d100_7_r", remainder, 2);
        chk("d100_7_dbz", div_by_zero, 0);
        tick();
        chk("d100_7_done_drop", done, 0);

        do_check("d255_1",   8'd255, 8'd1,   255, 0, 8);
        do_check("d255_255", 8'd255, 8'd255, 1,   0, 8);
        do_check("d5_9",     8'd5,   8'd9,   0,   5, 8);
        do_check("d37_0",    8'd37,  8'd0,   255, 37, 0);
        do_check("d40_6",    8'd40,  8'd6,   6,   4, 8);

        // Start during RUN is ignored; exactly one done pulse
        dividend = 8'd200; divisor = 8'd3; start = 1'b1;
        tick();                                   // edge 0
        start = 1'b0;
        tick(); tick();                           // edges 1,2
        dividend = 8'd9; divisor = 8'd2; start = 1'b1;
        tick();                                   // edge 3, ignored
        start = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                pulses++;
                chk("ign_q", quotient, 66);
                chk("ign_r", remainder, 2);
            end
            tick();
        end
        chk("ign_pulses", pulses, 1);

        // Reset mid-flight aborts with no done pulse
        dividend = 8'd200; divisor = 8'd3; start = 1'b1;
        tick();                                   // edge 0
        start = 1'b0;
        tick(); tick(); tick();                   // edges 1..3
        reset_n = 1'b0;
        tick();                                   // edge 4
        reset_n = 1'b1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        pulses = 0;
        for (int k = 0; k < 15; k++) begin
            if (done || busy) pulses++;
            tick();
        end
        chk("abort_no_activity", pulses, 0);
        do_check("d200_3", 8'd200, 8'd3, 66, 2, 8);

        // Random sweep, divisor nonzero
        for (int n = 0; n < 1000; n++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_div(a, b, lat, bc);
            chk("rnd_identity", int'(quotient) * int'(b) + int'(remainder), int'(a));
            chk("rnd_r_lt_d", (remainder < b) ? 1 : 0, 1);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
